// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and defaults for the Booth operand sequencer
package booth_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int TAG_W_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [2*WIDTH_DEF-1:0] product;
    logic [TAG_W_DEF-1:0]   tag;
  } result_t;

endpackage

// File: rtl/booth_result_fifo.sv
// rtl/booth_result_fifo.sv - first-word-fall-through result queue
module booth_result_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic              full_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == FULL_CNT);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && valid_o;
  // A pop on the same edge frees the slot, so a push into a full queue still lands.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - launches one Booth core operation at a time and queues tagged products
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int TAG_W       = TAG_W_DEF,
  parameter int LOAD_CYCLES = 1,
  parameter int TIMEOUT     = 15,
  parameter int DEPTH       = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_multiplicand,
  input  logic [WIDTH-1:0]   in_multiplier,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               mul_reset,
  output logic [WIDTH-1:0]   mul_multiplicand,
  output logic [WIDTH-1:0]   mul_multiplier,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               mul_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy,
  output logic               timeout_err
);

  localparam int DATA_W = 2*WIDTH + TAG_W;
  localparam int LC_W   = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam int WC_W   = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic [WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [TAG_W-1:0]  tag_q;
  logic [LC_W-1:0]   load_cnt_q;
  logic [WC_W-1:0]   wait_cnt_q;
  logic              mul_reset_q;
  logic              timeout_err_q;
  logic              fifo_full;
  logic              accept;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  assign in_ready         = (state_q == ST_IDLE) && !fifo_full;
  assign accept           = in_valid && in_ready;
  // Room was reserved at accept time, so a completion never finds the queue full.
  assign push             = (state_q == ST_WAIT) && mul_done;
  assign pop              = out_valid && out_ready;
  assign busy             = (state_q != ST_IDLE);
  assign timeout_err      = timeout_err_q;
  assign mul_reset        = mul_reset_q;
  assign mul_multiplicand = mcand_q;
  assign mul_multiplier   = mplier_q;
  assign out_product      = head[DATA_W-1:TAG_W];
  assign out_tag          = head[TAG_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mcand_q       <= '0;
      mplier_q      <= '0;
      tag_q         <= '0;
      load_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      mul_reset_q   <= 1'b1;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mul_reset_q <= accept;
          if (accept) begin
            mcand_q    <= in_multiplicand;
            mplier_q   <= in_multiplier;
            tag_q      <= in_tag;
            load_cnt_q <= '0;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_cnt_q == LC_W'(LOAD_CYCLES - 1)) begin
            mul_reset_q <= 1'b0;
            wait_cnt_q  <= '0;
            state_q     <= ST_WAIT;
          end else begin
            load_cnt_q <= load_cnt_q + LC_W'(1);
          end
        end
        ST_WAIT: begin
          if (mul_done) begin
            state_q <= ST_IDLE;
          end else if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + WC_W'(1);
          end
        end
        default: begin
          mul_reset_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  booth_result_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({mul_product, tag_q}),
    .pop_i       (pop),
    .valid_o     (out_valid),
    .full_o      (fifo_full),
    .head_o      (head)
  );

endmodule
